// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared state encoding and default counter width for the clock period monitor
package clk_mon_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, LOCKED = 2'd2, FAULT = 2'd3} state_t;
    localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/clk_period_monitor_if.sv
// clk_period_monitor_if: slow clock under test, fault clear and measurement/status outputs
//   master: drives slow_clk_i, clr_fault_i; observes status
//   slave : the monitor
interface clk_period_monitor_if import clk_mon_pkg::*; #(parameter int CNT_W = CNT_W_DEF);
    logic             slow_clk_i;
    logic             clr_fault_i;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             meas_valid_o;
    logic             in_range_o;
    logic             locked_o;
    logic             fault_o;
    logic             stuck_o;
    logic [1:0]       state_o;
    modport master (
        output slow_clk_i, clr_fault_i,
        input  period_o, high_o, meas_valid_o, in_range_o, locked_o, fault_o, stuck_o, state_o
    );
    modport slave (
        input  slow_clk_i, clr_fault_i,
        output period_o, high_o, meas_valid_o, in_range_o, locked_o, fault_o, stuck_o, state_o
    );
endinterface

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer plus delay flop and rising-edge detect
//   clk, rst_n (sync, active low) | d async input | s2 synchronized level | rise one-cycle edge
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic s2,
    output logic rise
);
    logic s1, s3;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end
    assign rise = s2 & ~s3;
endmodule

// File: rtl/clk_period_monitor.sv
// clk_period_monitor: measures period/high time of a slow clock, tracks lock and sticky faults
//   clk, rst_n (sync, active low) | mon: slow_clk_i, clr_fault_i in;
//   period_o, high_o, meas_valid_o, in_range_o, locked_o, fault_o, stuck_o, state_o out
module clk_period_monitor import clk_mon_pkg::*; #(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int EXP_PERIOD = 18,
    parameter int TOL        = 1,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    clk_period_monitor_if.slave   mon
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0]    LOCK_G = GW'(LOCK_CNT);
    localparam logic [CNT_W-1:0] TO     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W:0]   EXP    = (CNT_W+1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]   TOLV   = (CNT_W+1)'(TOL);
    logic             s2, rise, in_rng, timeout, meas, set_f;
    logic [CNT_W-1:0] cnt, hi_cnt;
    logic [CNT_W:0]   per, dev;
    logic [GW-1:0]    good, good_n;
    state_t           st, st_n;
    sync_edge_det u_sync (.clk(clk), .rst_n(rst_n), .d(mon.slow_clk_i), .s2(s2), .rise(rise));
    // one extra bit so a saturated count plus one never wraps
    assign per     = {1'b0, cnt} + (CNT_W+1)'(1);
    assign dev     = (per >= EXP) ? per - EXP : EXP - per;
    assign in_rng  = dev <= TOLV;
    assign timeout = !rise && cnt == TO_M1;
    // the first rise out of IDLE only starts timing
    assign meas    = rise && st != IDLE;
    assign set_f   = (meas && !in_rng) || timeout;
    always_comb begin
        st_n   = st;
        good_n = good;
        if (rise) begin
            if (st == IDLE) begin
                st_n   = ACQ;
                good_n = '0;
            end else if (!in_rng) begin
                st_n   = FAULT;
                good_n = '0;
            end else if (st != LOCKED) begin
                good_n = (st == FAULT) ? GW'(1) : good + GW'(1);
                st_n   = (good_n == LOCK_G) ? LOCKED : ACQ;
            end
        end else if (timeout) begin
            st_n   = FAULT;
            good_n = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt              <= '0;
            hi_cnt           <= '0;
            good             <= '0;
            st               <= IDLE;
            mon.period_o     <= '0;
            mon.high_o       <= '0;
            mon.meas_valid_o <= 1'b0;
            mon.in_range_o   <= 1'b0;
            mon.locked_o     <= 1'b0;
            mon.fault_o      <= 1'b0;
            mon.stuck_o      <= 1'b0;
            mon.state_o      <= 2'd0;
        end else begin
            cnt              <= rise ? '0 : (cnt == TO ? cnt : cnt + CNT_W'(1));
            hi_cnt           <= rise ? CNT_W'(1) : (&hi_cnt ? hi_cnt : hi_cnt + CNT_W'(s2));
            good             <= good_n;
            st               <= st_n;
            mon.meas_valid_o <= meas;
            if (meas) begin
                mon.period_o   <= per[CNT_W-1:0];
                mon.high_o     <= hi_cnt;
                mon.in_range_o <= in_rng;
            end
            mon.locked_o     <= st_n == LOCKED;
            mon.state_o      <= st_n;
            // a new fault in the same cycle as a clear leaves the flag set
            mon.fault_o      <= set_f || (mon.fault_o && !mon.clr_fault_i);
            mon.stuck_o      <= timeout || (mon.stuck_o && !mon.clr_fault_i);
        end
    end
endmodule
